// File: rtl/uart_cmd_slave.sv
// uart_cmd_slave: host command link endpoint.
// Assembles 16-bit commands from two UART bytes; serialises 8-bit responses.
module uart_cmd_slave #(
    parameter int BAUD_DIV     = 108,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frm_err
);

    localparam int BW       = $clog2(BAUD_DIV);
    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW       = $clog2(TO_LIMIT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        ASM_HIGH,
        ASM_LOW
    } asm_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    // ---------------- RX path ----------------
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    rx_state_t       rx_state_q, rx_state_d;
    logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            frm_err_q, frm_err_d;

    logic start_det;
    logic byte_vld;

    assign start_det = (rx_state_q == RX_IDLE) && rx_s3_q && !rx_s2_q;

    // Synchroniser plus one extra stage for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Receiver: mid-bit start check, then 8 data bits and stop at full bit spacing.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        frm_err_d  = 1'b0;
        byte_vld   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_det) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        byte_vld = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // ---------------- Command assembly ----------------
    asm_state_t      asm_q, asm_d;
    logic [7:0]      hi_q, hi_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            cmd_set;

    // High/low byte pairing with inter-byte timeout and ready handshake.
    always_comb begin
        asm_d    = asm_q;
        hi_d     = hi_q;
        to_cnt_d = to_cnt_q;
        cmd_d    = cmd_q;
        cmd_set  = 1'b0;
        case (asm_q)
            ASM_HIGH: begin
                to_cnt_d = '0;
                if (byte_vld) begin
                    hi_d  = rx_shift_q;
                    asm_d = ASM_LOW;
                end
            end
            ASM_LOW: begin
                if (byte_vld) begin
                    cmd_d    = {hi_q, rx_shift_q};
                    cmd_set  = 1'b1;
                    asm_d    = ASM_HIGH;
                    to_cnt_d = '0;
                end else if (start_det) begin
                    to_cnt_d = '0;
                end else if (rx_state_q == RX_IDLE) begin
                    if (to_cnt_q == TO_LAST) begin
                        asm_d    = ASM_HIGH;
                        hi_d     = '0;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            default: asm_d = ASM_HIGH;
        endcase
        if (frm_err_d) begin
            asm_d    = ASM_HIGH;
            to_cnt_d = '0;
        end

        cmd_rdy_d = cmd_rdy_q;
        if (cmd_set) begin
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (start_det && asm_q == ASM_HIGH)) begin
            cmd_rdy_d = 1'b0;
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= ASM_HIGH;
            hi_q      <= '0;
            to_cnt_q  <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            hi_q      <= hi_d;
            to_cnt_q  <= to_cnt_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    // ---------------- TX path ----------------
    tx_state_t       tx_state_q, tx_state_d;
    logic [BW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            resp_sent_c;

    // Transmitter: start bit on accept, then data LSB first and a stop bit.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        resp_sent_c = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_state_d = TX_BUSY;
                    tx_shift_d = {1'b1, resp};
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            TX_BUSY: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        resp_sent_c = 1'b1;
                        tx_state_d  = TX_IDLE;
                        tx_d        = 1'b1;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmitter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign TX        = tx_q;
    assign tx_busy   = (tx_state_q == TX_BUSY);
    assign resp_sent = resp_sent_c;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// tb_uart_cmd_slave: directed bench for uart_cmd_slave.
// Drives host UART frames and response requests; checks against hand values.
module tb_uart_cmd_slave;

    localparam int BAUD = 108;
    localparam int TOB  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frm_err;

    int n_cmp = 0;
    int n_bad = 0;
    int frm_cnt = 0;

    uart_cmd_slave #(
        .BAUD_DIV     (BAUD),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_err) frm_cnt = frm_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BAUD);
        end
        RX = stop;
        tick(BAUD);
        RX = 1'b1;
    endtask

    task automatic host_cmd(input logic [7:0] hi, input logic [7:0] lo);
        host_byte(hi, 1'b1);
        tick(BAUD);
        host_byte(lo, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit [9:0] pat;
        int rs_cnt;
        int rs_at;
        int fe0;
        int guard;

        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        send_resp = 1'b0;
        tick(3);
        check("rst_tx", 32'(TX), 32'h1);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_rdy", 32'(cmd_rdy), 32'h0);
        check("rst_busy", 32'(tx_busy), 32'h0);
        check("rst_sent", 32'(resp_sent), 32'h0);
        check("rst_ferr", 32'(frm_err), 32'h0);
        rst = 1'b0;
        tick(5);

        // Basic command and handshake
        host_cmd(8'h40, 8'h03);
        check("t1_rdy", 32'(cmd_rdy), 32'h1);
        check("t1_cmd", 32'(cmd), 32'h4003);
        tick(1000);
        check("t1_hold", 32'(cmd_rdy), 32'h1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("t1_clr", 32'(cmd_rdy), 32'h0);
        check("t1_cmd_keep", 32'(cmd), 32'h4003);

        // Response frame for 0xA5, with an ignored mid-frame request
        pat = 10'b1101001010;
        resp = 8'hA5;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        rs_cnt = 0;
        rs_at = 0;
        for (int k = 1; k <= 1081; k++) begin
            if (resp_sent) begin
                rs_cnt++;
                rs_at = k;
            end
            if (k <= 1080 && ((k - 1) % BAUD == 0 || (k - 1) % BAUD == BAUD - 1))
                check($sformatf("t2_bit%0d_k%0d", (k - 1) / BAUD, k),
                      32'(TX), 32'(pat[(k - 1) / BAUD]));
            if (k == 1080) check("t2_busy_end", 32'(tx_busy), 32'h1);
            if (k == 500) begin
                resp = 8'h00;
                send_resp = 1'b1;
            end else if (k == 501) begin
                send_resp = 1'b0;
            end
            if (k < 1081) tick(1);
        end
        check("t2_sent_cnt", 32'(rs_cnt), 32'd1);
        check("t2_sent_at", 32'(rs_at), 32'd1080);
        check("t2_busy_off", 32'(tx_busy), 32'h0);
        check("t2_tx_idle", 32'(TX), 32'h1);
        resp = 8'h0F;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        resp = 8'h00;
        check("t2_back2back_tx", 32'(TX), 32'h0);
        check("t2_back2back_busy", 32'(tx_busy), 32'h1);
        guard = 0;
        while (tx_busy && guard < 1200) begin
            tick(1);
            guard++;
        end
        check("t2_second_done", 32'(tx_busy), 32'h0);

        // Framing error on the low byte
        fe0 = frm_cnt;
        host_byte(8'h41, 1'b1);
        tick(BAUD);
        host_byte(8'h99, 1'b0);
        tick(BAUD);
        check("t3_ferr_cnt", 32'(frm_cnt - fe0), 32'd1);
        check("t3_rdy", 32'(cmd_rdy), 32'h0);
        host_cmd(8'h41, 8'h05);
        check("t3_cmd", 32'(cmd), 32'h4105);
        check("t3_rdy2", 32'(cmd_rdy), 32'h1);

        // Inter-byte timeout discards the high byte
        host_byte(8'h42, 1'b1);
        tick(40 * BAUD);
        check("t4_rdy_clr", 32'(cmd_rdy), 32'h0);
        host_cmd(8'h07, 8'h08);
        check("t4_cmd", 32'(cmd), 32'h0708);
        check("t4_rdy", 32'(cmd_rdy), 32'h1);

        // Short low glitch produces nothing
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        fe0 = frm_cnt;
        RX = 1'b0;
        tick(20);
        RX = 1'b1;
        tick(12 * BAUD);
        check("t5_ferr", 32'(frm_cnt - fe0), 32'd0);
        check("t5_rdy", 32'(cmd_rdy), 32'h0);
        host_cmd(8'h12, 8'h34);
        check("t5_cmd", 32'(cmd), 32'h1234);

        // Reset in the middle of RX and TX frames
        resp = 8'h3C;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        RX = 1'b0;
        tick(300);
        check("t6_busy_pre", 32'(tx_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_tx", 32'(TX), 32'h1);
        check("t6_busy", 32'(tx_busy), 32'h0);
        check("t6_rdy", 32'(cmd_rdy), 32'h0);
        check("t6_cmd", 32'(cmd), 32'h0);
        RX = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(5);
        check("t6_sent", 32'(resp_sent), 32'h0);
        host_cmd(8'h55, 8'hAA);
        check("t6_cmd2", 32'(cmd), 32'h55AA);
        check("t6_rdy2", 32'(cmd_rdy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
